updown_counter_driver: RTL
==========================

// Module: updown_counter_driver
// PURPOSE
//   Command-side initiator for the 5-bit load/up/down counter: drives its IN/Load/Up/Down inputs
//   to sweep the count as a triangle between programmable limits for N sweeps, and checks the
//   returned count against an internal shadow model. Sits between a test/config controller and
//   the counter; never issues an illegal command combination.
// PARAMETERS
//   WIDTH    5  counter data width (IN / counter bus)
//   SWEEP_W  8  width of sweep count / sweep counter
// PORTS
//   CLK          in   1        clock, all state on rising edge
//   RST_n        in   1        asynchronous active-low reset
//   start        in   1        1-cycle request; accepted only when busy=0
//   start_val    in   WIDTH    initial load value
//   lo_lim       in   WIDTH    lower turn-around value
//   hi_lim       in   WIDTH    upper turn-around value
//   n_sweeps     in   SWEEP_W  full up+down sweeps to run; 0 = run until abort
//   abort        in   1        stop current run
//   counter_in   in   WIDTH    count returned by counter
//   IN           out  WIDTH    load value to counter
//   Load/Up/Down out  1 each   counter commands, registered
//   busy         out  1        run in progress
//   done         out  1        1-cycle pulse at end of run (normal, abort or cfg error)
//   cfg_err      out  1        sticky until next accepted start: illegal config
//   cmp_err      out  1        sticky until next accepted start: count mismatch
//   sweep_cnt    out  SWEEP_W  completed sweeps this run
// BEHAVIOUR
//   Clock CLK; reset RST_n asynchronous, active-low. Reset (also mid-run): all outputs 0, state
//   IDLE, shadow 0, checker disarmed.
//   Config latched on accepted start; inputs ignored afterwards. Legal iff lo_lim<hi_lim and
//   lo_lim<=start_val<=hi_lim; else cfg_err=1, done pulse next cycle, no command ever issued.
//   States: IDLE -> LOAD -> {UP|DOWN} <-> ... -> DONE -> IDLE.
//   - LOAD: 1 cycle, Load=1, IN=start_val, shadow<=start_val. Next UP if start_val<hi_lim, else DOWN.
//   - UP: Up=1 every cycle, shadow+1; on cycle issuing shadow->hi_lim go DOWN (no idle gap).
//   - DOWN: Down=1 every cycle, shadow-1; on reaching lo_lim sweep_cnt++; if n_sweeps!=0 and
//     sweep_cnt+1==n_sweeps go DONE, else UP.
//   - DONE: 1 cycle, all commands 0, done=1, busy=0 next cycle.
//   - At most one of Load/Up/Down high in any cycle; IN held at latched start_val, 0 when IDLE.
//   - Shadow never exceeds [lo_lim,hi_lim], so no wrap at 0/2^WIDTH-1; counter High/Low saturation
//     is never relied on.
//   Latency: command issued at edge k is visible on counter_in after edge k+1; checker compares
//   counter_in to shadow delayed one cycle, armed from first cycle after LOAD until DONE.
//   Mismatch sets cmp_err; run continues (no recovery).
//   abort: from any busy state, next edge commands 0, state DONE (done pulse); sweep_cnt holds.
//   abort with start same cycle in IDLE: abort wins, start dropped. start while busy: ignored.
//   sweep_cnt saturates at all-ones in free-run mode.
// STRUCTURE
//   Package updown_drv_pkg: state enum (IDLE,LOAD,UP,DOWN,DONE), localparam CNT_MAX, cmd enum.
//   Sub-module updown_shadow_checker: shadow register, 1-cycle delay, compare, sticky cmp_err.
//   Top: FSM, config latch, sweep counter, registered command outputs.
// TESTING (bench instantiates real counter as responder)
//   start_val=3,lo=2,hi=5,n=1 -> Load(IN=3), Up x2, Down x3; count 3,4,5,4,3,2; done, sweep_cnt=1, no errs.
//   start_val=31,lo=0,hi=31,n=2 -> Load, Down x31, Up x31, Down x31; counter never wraps; sweep_cnt=2.
//   lo=6,hi=6 or start_val=9 with lo=2,hi=5 -> cfg_err=1, done 1 cycle later, Load/Up/Down never high.
//   n=0, abort after 40 cycles -> commands 0 next edge, done pulse, busy=0, sweep_cnt unchanged.
//   Force counter_in=7 while shadow expects 4 -> cmp_err=1 sticky, run still completes; cleared on next start.
//   RST_n low mid-UP -> all outputs 0 immediately; later start runs cleanly; assert Up&Down never both 1.

Source files
------------

// File: rtl/updown_drv_pkg.sv
// Shared state/command types and stepping helpers for the up/down counter driver.
package updown_drv_pkg;

   localparam int unsigned CNT_MAX = 31;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_UP,
      S_DOWN,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      CMD_NONE,
      CMD_LOAD,
      CMD_UP,
      CMD_DOWN
   } cmd_t;

   function automatic logic cfg_legal(input int unsigned sv, input int unsigned lo,
                                      input int unsigned hi);
      return (lo < hi) && (sv >= lo) && (sv <= hi);
   endfunction

   // Next command given the state that issued the current one and the shadow value it produced.
   function automatic cmd_t next_cmd(input state_t st, input int unsigned sh,
                                     input int unsigned lo, input int unsigned hi,
                                     input logic last);
      cmd_t c;
      c = CMD_NONE;
      case (st)
         S_LOAD: begin
            if (sh < hi) c = CMD_UP;
            else         c = CMD_DOWN;
         end
         S_UP: begin
            if (sh >= hi) c = CMD_DOWN;
            else          c = CMD_UP;
         end
         S_DOWN: begin
            if (sh <= lo) begin
               if (last) c = CMD_NONE;
               else      c = CMD_UP;
            end else begin
               c = CMD_DOWN;
            end
         end
         default: c = CMD_NONE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/updown_counter_driver_checker.sv
// Shadow of the counter value plus one-cycle-delayed comparison against the returned count.
module updown_shadow_checker
   import updown_drv_pkg::*;
#(
   parameter int unsigned WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  cmd_t             cmd,
   input  logic [WIDTH-1:0] load_val,
   input  logic             arm_set,
   input  logic             arm_clr,
   input  logic             err_clr,
   input  logic [WIDTH-1:0] counter_in,
   output logic [WIDTH-1:0] shadow,
   output logic             cmp_err
);

   logic [WIDTH-1:0] shadow_d;
   logic             armed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow   <= '0;
         shadow_d <= '0;
         armed    <= 1'b0;
         cmp_err  <= 1'b0;
      end else begin
         case (cmd)
            CMD_LOAD: shadow <= load_val;
            CMD_UP:   shadow <= shadow + 1'b1;
            CMD_DOWN: shadow <= shadow - 1'b1;
            default:  shadow <= shadow;
         endcase
         // The counter applies a command one edge after it is issued, so compare against the lagged shadow.
         shadow_d <= shadow;
         if (arm_clr)      armed <= 1'b0;
         else if (arm_set) armed <= 1'b1;
         if (err_clr)                              cmp_err <= 1'b0;
         else if (armed && (counter_in != shadow_d)) cmp_err <= 1'b1;
      end
   end

endmodule

// File: rtl/updown_counter_driver.sv
// Drives a load/up/down counter through triangle sweeps between latched limits and checks its count.
module updown_counter_driver
   import updown_drv_pkg::*;
#(
   parameter int unsigned WIDTH   = $clog2(CNT_MAX + 1),
   parameter int unsigned SWEEP_W = 8
) (
   input  logic               CLK,
   input  logic               RST_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   start_val,
   input  logic [WIDTH-1:0]   lo_lim,
   input  logic [WIDTH-1:0]   hi_lim,
   input  logic [SWEEP_W-1:0] n_sweeps,
   input  logic               abort,
   input  logic [WIDTH-1:0]   counter_in,
   output logic [WIDTH-1:0]   IN,
   output logic               Load,
   output logic               Up,
   output logic               Down,
   output logic               busy,
   output logic               done,
   output logic               cfg_err,
   output logic               cmp_err,
   output logic [SWEEP_W-1:0] sweep_cnt
);

   state_t             state;
   logic [WIDTH-1:0]   lo_q;
   logic [WIDTH-1:0]   hi_q;
   logic [SWEEP_W-1:0] n_q;
   logic [WIDTH-1:0]   shadow;
   logic               accept;
   logic               legal;
   logic               last_sweep;
   logic               sweep_end;
   cmd_t               issue;

   assign accept     = (state == S_IDLE) && start && !abort;
   assign legal      = cfg_legal(32'(start_val), 32'(lo_lim), 32'(hi_lim));
   assign last_sweep = (n_q != '0) && ((sweep_cnt + SWEEP_W'(1)) == n_q);
   assign sweep_end  = (state == S_DOWN) && (shadow == lo_q) && !abort;

   // Command issued at the coming edge; shared by the FSM and the shadow so both stay in lockstep.
   always_comb begin
      issue = CMD_NONE;
      if (accept) begin
         if (legal) issue = CMD_LOAD;
      end else if (!abort) begin
         issue = next_cmd(state, 32'(shadow), 32'(lo_q), 32'(hi_q), last_sweep);
      end
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state     <= S_IDLE;
         IN        <= '0;
         Load      <= 1'b0;
         Up        <= 1'b0;
         Down      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cfg_err   <= 1'b0;
         sweep_cnt <= '0;
         lo_q      <= '0;
         hi_q      <= '0;
         n_q       <= '0;
      end else begin
         Load <= (issue == CMD_LOAD);
         Up   <= (issue == CMD_UP);
         Down <= (issue == CMD_DOWN);
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  lo_q      <= lo_lim;
                  hi_q      <= hi_lim;
                  n_q       <= n_sweeps;
                  sweep_cnt <= '0;
                  busy      <= 1'b1;
                  if (legal) begin
                     state   <= S_LOAD;
                     IN      <= start_val;
                     cfg_err <= 1'b0;
                  end else begin
                     state   <= S_DONE;
                     done    <= 1'b1;
                     cfg_err <= 1'b1;
                  end
               end
            end
            S_LOAD, S_UP, S_DOWN: begin
               if (sweep_end && (sweep_cnt != '1)) sweep_cnt <= sweep_cnt + 1'b1;
               case (issue)
                  CMD_UP:   state <= S_UP;
                  CMD_DOWN: state <= S_DOWN;
                  default: begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end
               endcase
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               IN    <= '0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   updown_shadow_checker #(
      .WIDTH(WIDTH)
   ) u_checker (
      .clk       (CLK),
      .rst_n     (RST_n),
      .cmd       (issue),
      .load_val  (start_val),
      .arm_set   (state == S_LOAD),
      .arm_clr   (state == S_DONE),
      .err_clr   (accept),
      .counter_in(counter_in),
      .shadow    (shadow),
      .cmp_err   (cmp_err)
   );

endmodule
